red_pitaya_pfd_stimulus: RTL and testbench

//  Dual numerically controlled square-wave generator; drives the s1/s2 edge inputs of the PFD block.
//  Two phase accumulators produce two digital clocks with programmable frequencies and a relative phase offset.

---
 rtl/red_pitaya_pfd_stimulus.sv | 114 +++++++++++
 tb/tb_red_pitaya_pfd_stimulus.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pfd_stimulus.sv
// Dual NCO square-wave generator feeding the PFD s1/s2 inputs.
// Two phase accumulators with a relative start phase and an optional burst of N s1 periods.
`timescale 1ns/1ps
module red_pitaya_pfd_stimulus #(
    parameter int PHASEBITS = 32,
    parameter int CNTBITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [PHASEBITS-1:0] ftw1_i,
    input  logic [PHASEBITS-1:0] ftw2_i,
    input  logic [PHASEBITS-1:0] phase2_i,
    input  logic [CNTBITS-1:0]   burst_i,
    input  logic                 load_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic                 s1_o,
    output logic                 s2_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNTBITS-1:0]   edges1_o
);

    localparam int MSB = PHASEBITS - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [PHASEBITS-1:0] acc1, acc2, acc1_nxt, acc2_nxt;
    logic [PHASEBITS-1:0] ftw1, ftw2, ftw1_nxt, ftw2_nxt;
    logic [PHASEBITS-1:0] acc1_sum;
    logic [CNTBITS-1:0]   count, count_nxt, burst, burst_nxt;
    logic                 done_nxt;
    logic                 rise, fall;
    logic                 s1, s2, done;

    // MSB transitions of acc1 on the pending update define s1 edges
    assign acc1_sum = acc1 + ftw1;
    assign rise     = !acc1[MSB] &&  acc1_sum[MSB];
    assign fall     =  acc1[MSB] && !acc1_sum[MSB];

    always_comb begin
        state_nxt = state;
        acc1_nxt  = acc1;
        acc2_nxt  = acc2;
        ftw1_nxt  = ftw1;
        ftw2_nxt  = ftw2;
        count_nxt = count;
        burst_nxt = burst;
        done_nxt  = 1'b0;
        if (stop_i) begin
            if (state == RUN) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end else if (start_i) begin
            acc1_nxt  = '0;
            acc2_nxt  = phase2_i;
            count_nxt = '0;
            burst_nxt = burst_i;
            state_nxt = RUN;
        end else begin
            // New tuning words take effect from the next accumulation, keeping phase continuous
            if (load_i) begin
                ftw1_nxt = ftw1_i;
                ftw2_nxt = ftw2_i;
            end
            if (state == RUN) begin
                acc1_nxt = acc1_sum;
                acc2_nxt = acc2 + ftw2;
                if (rise)
                    count_nxt = count + 1'b1;
                if (fall && (burst != '0) && (count == burst)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            acc1  <= '0;
            acc2  <= '0;
            ftw1  <= '0;
            ftw2  <= '0;
            count <= '0;
            burst <= '0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc1  <= acc1_nxt;
            acc2  <= acc2_nxt;
            ftw1  <= ftw1_nxt;
            ftw2  <= ftw2_nxt;
            count <= count_nxt;
            burst <= burst_nxt;
            // Outputs follow the accumulator MSB one cycle late and drop to 0 once out of RUN
            s1    <= (state == RUN) && acc1[MSB];
            s2    <= (state == RUN) && acc2[MSB];
            done  <= done_nxt;
        end
    end

    assign s1_o     = s1;
    assign s2_o     = s2;
    assign busy_o   = (state == RUN);
    assign done_o   = done;
    assign edges1_o = count;

endmodule

// File: tb/tb_red_pitaya_pfd_stimulus.sv
// Bench for red_pitaya_pfd_stimulus: directed scenarios plus randomized strobes
// checked every cycle against a phase-arithmetic model of the generator.
`timescale 1ns/1ps
module tb_red_pitaya_pfd_stimulus;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] ftw1_i = '0, ftw2_i = '0, phase2_i = '0;
    logic [15:0] burst_i = '0;
    logic        load_i = 1'b0, start_i = 1'b0, stop_i = 1'b0;
    logic        s1_o, s2_o, busy_o, done_o;
    logic [15:0] edges1_o;

    int tests = 0;
    int fails = 0;

    red_pitaya_pfd_stimulus #(.PHASEBITS(32), .CNTBITS(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .ftw1_i(ftw1_i), .ftw2_i(ftw2_i), .phase2_i(phase2_i), .burst_i(burst_i),
        .load_i(load_i), .start_i(start_i), .stop_i(stop_i),
        .s1_o(s1_o), .s2_o(s2_o), .busy_o(busy_o), .done_o(done_o), .edges1_o(edges1_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: phase values as plain numbers mod 2^32; outputs are last cycle's phase half
    logic [31:0] m_ph1, m_ph2, m_f1, m_f2;
    logic [15:0] m_cnt, m_burst;
    bit          m_run, m_s1, m_s2, m_done;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_ph1 = 0; m_ph2 = 0; m_f1 = 0; m_f2 = 0;
            m_cnt = 0; m_burst = 0; m_run = 0;
            m_s1 = 0; m_s2 = 0; m_done = 0;
        end else begin
            longint unsigned p1_next;
            bit was_upper, now_upper;
            m_s1   = m_run && (m_ph1 >= 32'h8000_0000);
            m_s2   = m_run && (m_ph2 >= 32'h8000_0000);
            m_done = 0;
            if (stop_i) begin
                if (m_run) begin
                    m_run = 0;
                    m_done = 1;
                end
            end else if (start_i) begin
                m_ph1 = 0;
                m_ph2 = phase2_i;
                m_cnt = 0;
                m_burst = burst_i;
                m_run = 1;
            end else begin
                if (m_run) begin
                    was_upper = (m_ph1 >= 32'h8000_0000);
                    p1_next   = (longint'(m_ph1) + longint'(m_f1)) % 64'h1_0000_0000;
                    now_upper = (p1_next >= 64'h8000_0000);
                    m_ph1 = p1_next[31:0];
                    m_ph2 = m_ph2 + m_f2;
                    if (!was_upper && now_upper)
                        m_cnt = m_cnt + 1;
                    if (was_upper && !now_upper && m_burst != 0 && m_cnt == m_burst) begin
                        m_run = 0;
                        m_done = 1;
                    end
                end
                if (load_i) begin
                    m_f1 = ftw1_i;
                    m_f2 = ftw2_i;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i === 1'b1) begin
            chk("model_s1", s1_o, m_s1);
            chk("model_s2", s2_o, m_s2);
            chk("model_busy", busy_o, m_run);
            chk("model_done", done_o, m_done);
            chk("model_edges1", edges1_o, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_words(input logic [31:0] f1, input logic [31:0] f2);
        ftw1_i = f1; ftw2_i = f2; load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] ph2, input logic [15:0] n);
        phase2_i = ph2; burst_i = n; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic measure(input int n, output int p1, output int p2);
        int   l1 = -1, l2 = -1;
        logic o1, o2;
        o1 = s1_o; o2 = s2_o; p1 = 0; p2 = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            if (s1_o && !o1) begin if (l1 >= 0) p1 = k - l1; l1 = k; end
            if (s2_o && !o2) begin if (l2 >= 0) p2 = k - l2; l2 = k; end
            o1 = s1_o; o2 = s2_o;
        end
    endtask

    initial begin
        int first_rise, done_at, done_cnt, rises, bad, p1, p2;
        logic prev;

        rstn_i = 1'b0;
        #23;
        chk("reset_s1", s1_o, 0);
        chk("reset_s2", s2_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_edges1", edges1_o, 0);
        rstn_i = 1'b1;
        cyc();

        // Burst of 3 periods at fclk/4
        load_words(32'h4000_0000, 32'h4000_0000);
        do_start(32'h0, 16'd3);
        first_rise = -1; done_at = -1; done_cnt = 0; rises = 0; bad = 0; prev = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (s1_o && !prev) begin rises++; if (first_rise < 0) first_rise = k; end
            if (s1_o != s2_o) bad++;
            if (done_o) begin done_cnt++; done_at = k; chk("t1_busy_at_done", busy_o, 0); end
            prev = s1_o;
        end
        chk("t1_first_rise", first_rise, 3);
        chk("t1_done_cycle", done_at, 12);
        chk("t1_done_width", done_cnt, 1);
        chk("t1_rises", rises, 3);
        chk("t1_s1_eq_s2", bad, 0);
        chk("t1_edges1", edges1_o, 3);

        // Antiphase continuous, then stop
        do_start(32'h8000_0000, 16'd0);
        cyc();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (!busy_o || s2_o != !s1_o) bad++;
        end
        chk("t2_antiphase", bad, 0);
        stop_i = 1'b1; cyc(); stop_i = 1'b0;
        chk("t2_stop_done", done_o, 1);
        chk("t2_stop_busy", busy_o, 0);
        cyc();
        chk("t2_idle_s1", s1_o, 0);
        chk("t2_idle_s2", s2_o, 0);
        chk("t2_done_cleared", done_o, 0);

        // Two frequencies, continuous
        load_words(32'h1000_0000, 32'h2000_0000);
        do_start(32'h0, 16'd0);
        measure(60, p1, p2);
        chk("t3_s1_period", p1, 16);
        chk("t3_s2_period", p2, 8);

        // Retune in RUN: period 4 -> 8
        load_words(32'h4000_0000, 32'h4000_0000);
        do_start(32'h0, 16'd0);
        measure(12, p1, p2);
        chk("t4_period_before", p1, 4);
        load_words(32'h2000_0000, 32'h4000_0000);
        measure(30, p1, p2);
        chk("t4_period_after", p1, 8);

        // start+stop together in RUN, then in IDLE
        start_i = 1'b1; stop_i = 1'b1; cyc(); start_i = 1'b0; stop_i = 1'b0;
        chk("t5_run_done", done_o, 1);
        chk("t5_run_busy", busy_o, 0);
        cyc();
        start_i = 1'b1; stop_i = 1'b1; cyc(); start_i = 1'b0; stop_i = 1'b0;
        chk("t5_idle_done", done_o, 0);
        chk("t5_idle_busy", busy_o, 0);

        // Asynchronous reset mid-burst
        load_words(32'h2000_0000, 32'h2000_0000);
        do_start(32'h0, 16'd5);
        for (int k = 0; k < 13; k++) cyc();
        #2 rstn_i = 1'b0;
        #1;
        chk("t6_s1", s1_o, 0);
        chk("t6_s2", s2_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_edges1", edges1_o, 0);
        #3 rstn_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (busy_o || s1_o || s2_o || done_o) bad++;
        end
        chk("t6_quiet_after_reset", bad, 0);

        // Randomized strobes and tuning words
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0:       ftw1_i = 32'h0;
                    1:       ftw1_i = $urandom;
                    default: ftw1_i = $urandom_range(32'h0400_0000, 32'h8000_0000);
                endcase
                ftw2_i = ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(32'h0400_0000, 32'h8000_0000);
                load_i = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                phase2_i = $urandom;
                burst_i  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
                start_i  = 1'b1;
            end
            if ($urandom_range(0, 399) == 0) stop_i = 1'b1;
            cyc();
            load_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
            if (k % 1500 == 1499) begin
                #3 rstn_i = 1'b0;
                #2 rstn_i = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
